reg_cc_stack: RTL

Parametrised condition-code unit for the LC-3 datapath: derives N/Z/P from the bus word on load, registers it, and evaluates the branch-enable bit. Adds a LIFO save/restore stack so interrupt/trap entry can push the live NZP and RTI can pop it back. Sits beside the IR and feeds BEN to the control FSM.

---
 rtl/reg_cc_stack_if.sv | 31 +++
 rtl/reg_cc_stack.sv | 99 +++++++++
 2 files changed

// File: rtl/reg_cc_stack_if.sv
// reg_cc_stack_if: control/data bundle between the LC-3 datapath
// and the condition-code unit with its NZP save stack.
interface reg_cc_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             Load;
    logic [WIDTH-1:0] BUS;
    logic             Push;
    logic             Pop;
    logic             Ld_BEN;
    logic [2:0]       Cond;
    logic [2:0]       Data_Out;
    logic             BEN;
    logic [CW-1:0]    Count;
    logic             Full;
    logic             Empty;
    logic             Err;

    modport master (
        output Load, BUS, Push, Pop, Ld_BEN, Cond,
        input  Data_Out, BEN, Count, Full, Empty, Err
    );

    modport slave (
        input  Load, BUS, Push, Pop, Ld_BEN, Cond,
        output Data_Out, BEN, Count, Full, Empty, Err
    );
endinterface

// File: rtl/reg_cc_stack.sv
// reg_cc_stack: NZP condition-code register, branch-enable register
// and a LIFO save stack for interrupt/trap entry and RTI.
module reg_cc_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    reg_cc_stack_if.slave        bif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SN = 1 << IW;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [2:0]    nzp_q, nzp_d;
    logic          ben_q, ben_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [2:0]    stack_q [SN];

    logic [2:0]    cls;
    logic          full, empty;
    logic          both, push_ok, pop_ok, misuse;
    logic [CW-1:0] cnt_dec;
    logic [IW-1:0] wr_idx, rd_idx;

    // Classify the bus word into a one-hot NZP code
    always_comb begin
        cls = 3'b001;
        if (bif.BUS == '0) begin
            cls = 3'b010;
        end else if (bif.BUS[WIDTH-1]) begin
            cls = 3'b100;
        end
    end

    assign full    = (cnt_q == CNT_MAX);
    assign empty   = (cnt_q == '0);
    assign both    = bif.Push & bif.Pop;
    assign push_ok = bif.Push & ~bif.Pop & ~full;
    assign pop_ok  = bif.Pop & ~bif.Push & ~empty;
    assign misuse  = both
                   | (bif.Push & ~bif.Pop & full)
                   | (bif.Pop & ~bif.Push & empty);
    assign cnt_dec = cnt_q - CNT_ONE;
    assign wr_idx  = cnt_q[IW-1:0];
    assign rd_idx  = cnt_dec[IW-1:0];

    // Next-state: a successful pop wins over load; BEN sees the old NZP
    always_comb begin
        nzp_d = nzp_q;
        ben_d = ben_q;
        cnt_d = cnt_q;
        err_d = err_q | misuse;
        if (pop_ok) begin
            nzp_d = stack_q[rd_idx];
            cnt_d = cnt_dec;
        end else if (bif.Load) begin
            nzp_d = cls;
        end
        if (push_ok) begin
            cnt_d = cnt_q + CNT_ONE;
        end
        if (bif.Ld_BEN) begin
            ben_d = |(bif.Cond & nzp_q);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            nzp_q <= 3'b000;
            ben_q <= 1'b0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            nzp_q <= nzp_d;
            ben_q <= ben_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Save stack storage; contents are don't-care after reset
    always_ff @(posedge Clk) begin
        if (!Reset && push_ok) begin
            stack_q[wr_idx] <= nzp_q;
        end
    end

    assign bif.Data_Out = nzp_q;
    assign bif.BEN      = ben_q;
    assign bif.Count    = cnt_q;
    assign bif.Full     = full;
    assign bif.Empty    = empty;
    assign bif.Err      = err_q;
endmodule
